// File: rtl/spla_bus_pkg.sv
// rtl/spla_bus_pkg.sv - shared widths, default timing and phase encoding for the pin bus sequencer
package spla_bus_pkg;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;

    localparam int DEF_T_SETUP  = 1;
    localparam int DEF_T_STROBE = 2;
    localparam int DEF_T_HOLD   = 1;
    localparam int DEF_T_TURN   = 1;
    localparam int DEF_CNT_W    = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        TURN
    } bus_state_t;
endpackage

// File: rtl/pin_bus_phase_cnt.sv
// rtl/pin_bus_phase_cnt.sv - phase length down-counter with load, decrement and zero flag
module pin_bus_phase_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/pin_bus_sequencer.sv
// rtl/pin_bus_sequencer.sv - single-outstanding read/write sequencer for a strobed parallel pad bus
module pin_bus_sequencer
    import spla_bus_pkg::*;
#(
    parameter int T_SETUP  = DEF_T_SETUP,
    parameter int T_STROBE = DEF_T_STROBE,
    parameter int T_HOLD   = DEF_T_HOLD,
    parameter int T_TURN   = DEF_T_TURN,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] addr_o,
    output logic              addr_dir,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_dir,
    output logic              rd_n,
    output logic              wr_n
);
    bus_state_t       state;
    bus_state_t       nxt;
    logic             write_q;
    logic             cur_write;
    logic             advance;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    // Zero-length phases are never entered, so the sequence folds straight past them.
    function automatic bus_state_t next_phase(input bus_state_t s, input logic wr);
        case (s)
            IDLE:    return (T_SETUP > 0) ? SETUP : STROBE;
            SETUP:   return STROBE;
            STROBE:  begin
                if (T_HOLD > 0)               return HOLD;
                else if (wr && (T_TURN > 0))  return TURN;
                else                          return IDLE;
            end
            HOLD:    return (wr && (T_TURN > 0)) ? TURN : IDLE;
            default: return IDLE;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] phase_len(input bus_state_t s);
        case (s)
            SETUP:   return CNT_W'(T_SETUP - 1);
            STROBE:  return CNT_W'(T_STROBE - 1);
            HOLD:    return CNT_W'(T_HOLD - 1);
            TURN:    return CNT_W'(T_TURN - 1);
            default: return '0;
        endcase
    endfunction

    always_comb begin
        cur_write = (state == IDLE) ? req_write : write_q;
        advance   = (state == IDLE) ? req_valid : cnt_zero;
        nxt       = next_phase(state, cur_write);
        cnt_load  = advance;
        cnt_val   = phase_len(nxt);
        cnt_dec   = !advance && (state != IDLE);
    end

    pin_bus_phase_cnt #(
        .CNT_W(CNT_W)
    ) u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            write_q   <= 1'b0;
            rd_n      <= 1'b1;
            wr_n      <= 1'b1;
            data_dir  <= 1'b0;
            addr_dir  <= 1'b0;
            addr_o    <= '0;
            data_o    <= '0;
            rsp_rdata <= '0;
            rsp_valid <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (advance) begin
                state <= nxt;
                rd_n  <= !((nxt == STROBE) && !cur_write);
                wr_n  <= !((nxt == STROBE) && cur_write);
                if (state == IDLE) begin
                    write_q  <= req_write;
                    addr_o   <= req_addr;
                    addr_dir <= 1'b1;
                    data_dir <= req_write;
                    if (req_write) begin
                        data_o <= req_wdata;
                    end
                end
                // Bus is released as soon as the strobe/hold window of a write closes.
                if ((nxt == TURN) || (nxt == IDLE)) begin
                    data_dir <= 1'b0;
                end
                if ((state == STROBE) && !write_q) begin
                    rsp_rdata <= data_i;
                    rsp_valid <= 1'b1;
                end
            end
        end
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_pin_bus_sequencer.sv
// tb/tb_pin_bus_sequencer.sv - randomized self-checking bench with a cycle-timeline reference model
module tb_pin_bus_sequencer;
    logic clk;
    logic rst_n;

    logic [1:0]       req_valid;
    logic [1:0]       req_write;
    logic [1:0][13:0] req_addr;
    logic [1:0][7:0]  req_wdata;
    logic [1:0][7:0]  data_i;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_valid;
    logic [1:0][7:0]  rsp_rdata;
    logic [1:0]       busy;
    logic [1:0][13:0] addr_o;
    logic [1:0]       addr_dir;
    logic [1:0][7:0]  data_o;
    logic [1:0]       data_dir;
    logic [1:0]       rd_n;
    logic [1:0]       wr_n;

    int n_checks;
    int n_fail;
    int ts  [2];
    int tst [2];
    int th  [2];
    int tt  [2];
    logic [7:0] last_rdata [2];
    logic [7:0] last_wdata [2];

    pin_bus_sequencer u_def (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
        .addr_o(addr_o[0]), .addr_dir(addr_dir[0]), .data_i(data_i[0]),
        .data_o(data_o[0]), .data_dir(data_dir[0]), .rd_n(rd_n[0]), .wr_n(wr_n[0])
    );

    pin_bus_sequencer #(
        .T_SETUP(0), .T_STROBE(1), .T_HOLD(0), .T_TURN(0)
    ) u_fast (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
        .addr_o(addr_o[1]), .addr_dir(addr_dir[1]), .data_i(data_i[1]),
        .data_o(data_o[1]), .data_dir(data_dir[1]), .rd_n(rd_n[1]), .wr_n(wr_n[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected pins at cycle k after acceptance follow directly from the phase lengths.
    task automatic do_txn(input int u, input bit wr, input logic [13:0] a, input logic [7:0] d,
                          input logic [7:0] rdv, input bit hold);
        int n;
        int cap;
        bit strobe;
        logic [1:0] e_str;
        logic [1:0] e_dir;
        logic [2:0] e_hs;
        logic [7:0] e_do;
        logic [7:0] e_rd;
        n   = 1 + ts[u] + tst[u] + th[u] + (wr ? tt[u] : 0);
        cap = ts[u] + tst[u];
        n_checks++;
        if (req_ready[u] !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_at_request inst%0d: got %b expected 1", u, req_ready[u]);
        end
        req_valid[u] = 1'b1;
        req_write[u] = wr;
        req_addr[u]  = a;
        req_wdata[u] = d;
        data_i[u]    = 8'($urandom);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            @(negedge clk);
            strobe = (k >= ts[u] + 1) && (k <= cap);
            e_str  = {!(strobe && !wr), !(strobe && wr)};
            e_dir  = {1'b1, wr && (k <= cap + th[u])};
            e_hs   = {k == n, k < n, !wr && (k == cap + 1)};
            e_do   = wr ? d : last_wdata[u];
            e_rd   = (!wr && (k > cap)) ? rdv : last_rdata[u];
            n_checks++;
            if ({rd_n[u], wr_n[u]} !== e_str) begin
                n_fail++;
                $display("FAIL strobes inst%0d cycle %0d wr=%0d: got rd_n,wr_n=%b expected %b", u, k, wr, {rd_n[u], wr_n[u]}, e_str);
            end
            n_checks++;
            if ({addr_dir[u], data_dir[u]} !== e_dir) begin
                n_fail++;
                $display("FAIL directions inst%0d cycle %0d wr=%0d: got addr_dir,data_dir=%b expected %b", u, k, wr, {addr_dir[u], data_dir[u]}, e_dir);
            end
            n_checks++;
            if ({req_ready[u], busy[u], rsp_valid[u]} !== e_hs) begin
                n_fail++;
                $display("FAIL handshake inst%0d cycle %0d wr=%0d: got ready,busy,rsp_valid=%b expected %b", u, k, wr, {req_ready[u], busy[u], rsp_valid[u]}, e_hs);
            end
            n_checks++;
            if (addr_o[u] !== a) begin
                n_fail++;
                $display("FAIL addr_o inst%0d cycle %0d: got %h expected %h", u, k, addr_o[u], a);
            end
            n_checks++;
            if (data_o[u] !== e_do) begin
                n_fail++;
                $display("FAIL data_o inst%0d cycle %0d: got %h expected %h", u, k, data_o[u], e_do);
            end
            n_checks++;
            if (rsp_rdata[u] !== e_rd) begin
                n_fail++;
                $display("FAIL rsp_rdata inst%0d cycle %0d: got %h expected %h", u, k, rsp_rdata[u], e_rd);
            end
            req_valid[u] = hold;
            req_write[u] = 1'($urandom);
            req_addr[u]  = 14'($urandom);
            req_wdata[u] = 8'($urandom);
            data_i[u]    = (k == cap) ? rdv : 8'($urandom);
        end
        if (wr) last_wdata[u] = d;
        else    last_rdata[u] = rdv;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            n_checks++;
            if ({rd_n[u], wr_n[u], data_dir[u], addr_dir[u], rsp_valid[u]} !== 5'b11000) begin
                n_fail++;
                $display("FAIL reset_pins inst%0d: got rd_n,wr_n,data_dir,addr_dir,rsp_valid=%b expected 11000", u,
                         {rd_n[u], wr_n[u], data_dir[u], addr_dir[u], rsp_valid[u]});
            end
            n_checks++;
            if ({addr_o[u], data_o[u], rsp_rdata[u]} !== 30'd0) begin
                n_fail++;
                $display("FAIL reset_values inst%0d: got addr_o,data_o,rsp_rdata=%h expected 0", u, {addr_o[u], data_o[u], rsp_rdata[u]});
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            n_checks++;
            if ({req_ready[u], busy[u]} !== 2'b10) begin
                n_fail++;
                $display("FAIL ready_after_reset inst%0d: got ready,busy=%b expected 10", u, {req_ready[u], busy[u]});
            end
            last_rdata[u] = 8'h00;
            last_wdata[u] = 8'h00;
        end
    endtask

    task automatic test_read();
        do_txn(0, 1'b0, 14'h1234, 8'h00, 8'hA5, 1'b0);
    endtask

    task automatic test_write();
        do_txn(0, 1'b1, 14'h3FFF, 8'h5A, 8'h00, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_txn(0, 1'b1, 14'h0ABC, 8'hC3, 8'h00, 1'b1);
        do_txn(0, 1'b0, 14'h0ABC, 8'h00, 8'h3C, 1'b1);
        do_txn(0, 1'b0, 14'h0001, 8'h00, 8'hE7, 1'b0);
    endtask

    task automatic test_fast_timing();
        do_txn(1, 1'b0, 14'h0155, 8'h00, 8'h96, 1'b1);
        do_txn(1, 1'b0, 14'h02AA, 8'h00, 8'h69, 1'b1);
        do_txn(1, 1'b1, 14'h3000, 8'hF0, 8'h00, 1'b1);
        do_txn(1, 1'b0, 14'h0000, 8'h00, 8'h0F, 1'b0);
    endtask

    task automatic test_random();
        int u;
        int len;
        for (int i = 0; i < 30; i++) begin
            u   = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 4));
            for (int j = 0; j < len; j++) begin
                do_txn(u, 1'($urandom), 14'($urandom), 8'($urandom), 8'($urandom), j != len - 1);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_abort();
        for (int w = 0; w < 2; w++) begin
            req_valid[0] = 1'b1;
            req_write[0] = (w == 1);
            req_addr[0]  = 14'h2222;
            req_wdata[0] = 8'h77;
            data_i[0]    = 8'h11;
            @(posedge clk);
            @(negedge clk);
            req_valid[0] = 1'b0;
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if ({rd_n[0], wr_n[0]} !== ((w == 1) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL strobe_before_abort wr=%0d: got rd_n,wr_n=%b", w, {rd_n[0], wr_n[0]});
            end
            rst_n = 1'b0;
            #1;
            n_checks++;
            if ({rd_n[0], wr_n[0], data_dir[0], addr_dir[0], busy[0], rsp_valid[0]} !== 6'b110000) begin
                n_fail++;
                $display("FAIL async_abort wr=%0d: got rd_n,wr_n,data_dir,addr_dir,busy,rsp_valid=%b expected 110000", w,
                         {rd_n[0], wr_n[0], data_dir[0], addr_dir[0], busy[0], rsp_valid[0]});
            end
            @(negedge clk);
            rst_n = 1'b1;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                n_checks++;
                if ({rsp_valid[0], req_ready[0], rsp_rdata[0]} !== {2'b01, 8'h00}) begin
                    n_fail++;
                    $display("FAIL no_response_after_abort cycle %0d: got rsp_valid,ready,rdata=%h expected 100", k,
                             {rsp_valid[0], req_ready[0], rsp_rdata[0]});
                end
            end
        end
        last_rdata[0] = 8'h00;
        last_wdata[0] = 8'h00;
        last_rdata[1] = 8'h00;
        last_wdata[1] = 8'h00;
        do_txn(0, 1'b0, 14'h0042, 8'h00, 8'hB4, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ts[0] = 1; tst[0] = 2; th[0] = 1; tt[0] = 1;
        ts[1] = 0; tst[1] = 1; th[1] = 0; tt[1] = 0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        data_i    = '0;
        rst_n     = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_fast_timing();
        test_random();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
